slv_guard_cfg_master: RTL and testbench

- Autonomous register-bus initiator that programs a slave-guard configuration port after reset, replacing a software or testbench register driver.
- On start, issues an ordered list of register writes: unit enable, write budget, read budget, and so on. Each write uses a valid/ready handshake.
- Retries writes that return a bus error, aborts on timeout, and reports completion or failure through status outputs and a sticky error code.
- Sits between the boot/reset controller and the guard's reg_req/reg_rsp port.

---
 rtl/slv_guard_cfg_master.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_slv_guard_cfg_master.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slv_guard_cfg_master.sv
// slv_guard_cfg_master
// Autonomous register-bus initiator that programs a slave-guard configuration
// port after reset. On start_i it walks an ordered table of (addr, data, strb)
// entries and issues one write per entry over a valid/ready register bus.
// Writes that return a bus error are retried a bounded number of times. A
// request that waits too long for ready is aborted. The outcome is reported
// through busy_o / done_o and a sticky err_o with an error code and entry index.
//
// Build option:
//   SLV_GUARD_CFG_READBACK_EN - after each successful write, read the same
//   address back and compare the strobed bytes. A difference aborts the
//   sequence with error code 3.
//
// Reset note: rst_n is asynchronous and active-HIGH, which matches the
// surrounding codebase despite its name.
`timescale 1ns/1ps
module slv_guard_cfg_master #(
  parameter int  AddrWidth     = 32,
  parameter int  DataWidth     = 32,
  parameter int  NumEntries    = 3,
  parameter int  MaxRetries    = 3,
  parameter int  TimeoutCycles = 256,
  localparam int StrbWidth     = DataWidth / 8,
  localparam int IdxWidth      = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start_i,
  input  logic [NumEntries*AddrWidth-1:0]  cfg_addr_i,
  input  logic [NumEntries*DataWidth-1:0]  cfg_data_i,
  input  logic [NumEntries*StrbWidth-1:0]  cfg_strb_i,
  output logic [AddrWidth-1:0]             reg_addr_o,
  output logic [DataWidth-1:0]             reg_wdata_o,
  output logic [StrbWidth-1:0]             reg_wstrb_o,
  output logic                             reg_write_o,
  output logic                             reg_valid_o,
  input  logic [DataWidth-1:0]             reg_rdata_i,
  input  logic                             reg_error_i,
  input  logic                             reg_ready_i,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o,
  output logic [1:0]                       err_code_o,
  output logic [IdxWidth-1:0]              err_idx_o
);

  localparam int RetryWidth = (MaxRetries > 0) ? $clog2(MaxRetries + 1) : 1;
  localparam int TmoWidth   = $clog2(TimeoutCycles);

  localparam logic [RetryWidth-1:0] RetryMax = RetryWidth'(MaxRetries);
  localparam logic [TmoWidth-1:0]   TmoLast  = TmoWidth'(TimeoutCycles - 1);
  localparam logic [IdxWidth-1:0]   IdxLast  = IdxWidth'(NumEntries - 1);

  localparam logic [1:0] ErrBus     = 2'd1;
  localparam logic [1:0] ErrTimeout = 2'd2;
`ifdef SLV_GUARD_CFG_READBACK_EN
  localparam logic [1:0] ErrReadback = 2'd3;
`endif

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RETRY = 3'd2,
    ST_NEXT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
`ifdef SLV_GUARD_CFG_READBACK_EN
    ,
    ST_RDBK  = 3'd6
`endif
  } state_t;

  state_t                state_r;
  logic [IdxWidth-1:0]   idx_r;
  logic [RetryWidth-1:0] retry_r;
  logic [TmoWidth-1:0]   tmo_r;

  logic [IdxWidth-1:0]   sel_idx_s;
  logic [AddrWidth-1:0]  ent_addr_s;
  logic [DataWidth-1:0]  ent_data_s;
  logic [StrbWidth-1:0]  ent_strb_s;
  logic                  retry_left_s;
  logic                  tmo_expired_s;

  assign retry_left_s  = (retry_r < RetryMax);
  assign tmo_expired_s = (tmo_r == TmoLast);

`ifdef SLV_GUARD_CFG_READBACK_EN
  logic rdbk_r;
  logic rdbk_mismatch_s;

  // Expand each byte strobe into a full byte of compare mask.
  function automatic logic [DataWidth-1:0] strb_to_mask(input logic [StrbWidth-1:0] strb);
    logic [DataWidth-1:0] mask;
    mask = '0;
    for (int b = 0; b < StrbWidth; b++) begin
      mask[b*8 +: 8] = {8{strb[b]}};
    end
    return mask;
  endfunction

  assign rdbk_mismatch_s = |((reg_rdata_i ^ reg_wdata_o) & strb_to_mask(reg_wstrb_o));
`else
  // Read data is only consumed by the read-back option; keep it as a named sink.
  logic unused_rdata_s;
  assign unused_rdata_s = ^reg_rdata_i;
`endif

  // Pick which table entry the next request will be loaded from.
  always_comb begin
    sel_idx_s = idx_r;
    case (state_r)
      ST_IDLE, ST_ERR: sel_idx_s = '0;
      ST_NEXT:         sel_idx_s = idx_r + 1'b1;
      default:         sel_idx_s = idx_r;
    endcase
  end

  // Mux the selected entry out of the flattened configuration table.
  always_comb begin
    ent_addr_s = '0;
    ent_data_s = '0;
    ent_strb_s = '0;
    for (int i = 0; i < NumEntries; i++) begin
      ent_addr_s = ent_addr_s | ((sel_idx_s == IdxWidth'(i)) ? cfg_addr_i[i*AddrWidth +: AddrWidth] : '0);
      ent_data_s = ent_data_s | ((sel_idx_s == IdxWidth'(i)) ? cfg_data_i[i*DataWidth +: DataWidth] : '0);
      ent_strb_s = ent_strb_s | ((sel_idx_s == IdxWidth'(i)) ? cfg_strb_i[i*StrbWidth +: StrbWidth] : '0);
    end
  end

  // Sequencer FSM with all bus and status outputs registered.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_r     <= ST_IDLE;
      idx_r       <= '0;
      retry_r     <= '0;
      tmo_r       <= '0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_wstrb_o <= '0;
      reg_write_o <= 1'b0;
      reg_valid_o <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
      err_o       <= 1'b0;
      err_code_o  <= 2'd0;
      err_idx_o   <= '0;
`ifdef SLV_GUARD_CFG_READBACK_EN
      rdbk_r      <= 1'b0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state_r)
        ST_IDLE, ST_ERR: begin
          if (start_i) begin
            state_r     <= ST_REQ;
            idx_r       <= '0;
            retry_r     <= '0;
            tmo_r       <= '0;
            reg_addr_o  <= ent_addr_s;
            reg_wdata_o <= ent_data_s;
            reg_wstrb_o <= ent_strb_s;
            reg_write_o <= 1'b1;
            reg_valid_o <= 1'b1;
            busy_o      <= 1'b1;
            err_o       <= 1'b0;
            err_code_o  <= 2'd0;
            err_idx_o   <= '0;
`ifdef SLV_GUARD_CFG_READBACK_EN
            rdbk_r      <= 1'b0;
`endif
          end else begin
            reg_valid_o <= 1'b0;
          end
        end

        ST_REQ: begin
          if (reg_ready_i) begin
            tmo_r <= '0;
            if (!reg_error_i) begin
`ifdef SLV_GUARD_CFG_READBACK_EN
              // Same address, now as a read; a fresh request with its own timeout.
              state_r     <= ST_RDBK;
              reg_write_o <= 1'b0;
              reg_valid_o <= 1'b1;
              rdbk_r      <= 1'b1;
`else
              state_r     <= ST_NEXT;
              reg_valid_o <= 1'b0;
`endif
            end else if (retry_left_s) begin
              retry_r     <= retry_r + 1'b1;
              state_r     <= ST_RETRY;
              reg_valid_o <= 1'b0;
            end else begin
              state_r     <= ST_ERR;
              reg_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              err_o       <= 1'b1;
              err_code_o  <= ErrBus;
              err_idx_o   <= idx_r;
            end
          end else if (tmo_expired_s) begin
            state_r     <= ST_ERR;
            reg_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b1;
            err_code_o  <= ErrTimeout;
            err_idx_o   <= idx_r;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end

`ifdef SLV_GUARD_CFG_READBACK_EN
        ST_RDBK: begin
          if (reg_ready_i) begin
            tmo_r <= '0;
            if (reg_error_i) begin
              if (retry_left_s) begin
                retry_r     <= retry_r + 1'b1;
                state_r     <= ST_RETRY;
                reg_valid_o <= 1'b0;
              end else begin
                state_r     <= ST_ERR;
                reg_valid_o <= 1'b0;
                busy_o      <= 1'b0;
                err_o       <= 1'b1;
                err_code_o  <= ErrBus;
                err_idx_o   <= idx_r;
              end
            end else if (rdbk_mismatch_s) begin
              state_r     <= ST_ERR;
              reg_valid_o <= 1'b0;
              busy_o      <= 1'b0;
              err_o       <= 1'b1;
              err_code_o  <= ErrReadback;
              err_idx_o   <= idx_r;
            end else begin
              state_r     <= ST_NEXT;
              reg_valid_o <= 1'b0;
            end
          end else if (tmo_expired_s) begin
            state_r     <= ST_ERR;
            reg_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            err_o       <= 1'b1;
            err_code_o  <= ErrTimeout;
            err_idx_o   <= idx_r;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
`endif

        ST_RETRY: begin
          // One idle cycle, then re-issue whichever access failed.
          tmo_r       <= '0;
          reg_valid_o <= 1'b1;
`ifdef SLV_GUARD_CFG_READBACK_EN
          state_r     <= rdbk_r ? ST_RDBK : ST_REQ;
`else
          state_r     <= ST_REQ;
`endif
        end

        ST_NEXT: begin
          if (idx_r == IdxLast) begin
            state_r     <= ST_DONE;
            reg_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b1;
          end else begin
            state_r     <= ST_REQ;
            idx_r       <= idx_r + 1'b1;
            retry_r     <= '0;
            tmo_r       <= '0;
            reg_addr_o  <= ent_addr_s;
            reg_wdata_o <= ent_data_s;
            reg_wstrb_o <= ent_strb_s;
            reg_write_o <= 1'b1;
            reg_valid_o <= 1'b1;
`ifdef SLV_GUARD_CFG_READBACK_EN
            rdbk_r      <= 1'b0;
`endif
          end
        end

        ST_DONE: begin
          state_r     <= ST_IDLE;
          reg_valid_o <= 1'b0;
        end

        default: begin
          state_r     <= ST_IDLE;
          reg_valid_o <= 1'b0;
          busy_o      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slv_guard_cfg_master.sv
// Self-checking bench for slv_guard_cfg_master.
// A responder process models the register slave (latency, injected errors,
// stalls, read data); a monitor records every completed transfer; a
// transaction-level model predicts the transfer list and final status.
`timescale 1ns/1ps
module tb_slv_guard_cfg_master;

  localparam int NE   = 3;
  localparam int MAXR = 3;
  localparam int TMO  = 16;

  typedef struct packed {
    logic        wr;
    logic        er;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } rec_t;

  logic             clk;
  logic             rst_n;
  logic             start_i;
  logic [NE*32-1:0] cfg_addr_i;
  logic [NE*32-1:0] cfg_data_i;
  logic [NE*4-1:0]  cfg_strb_i;
  logic [31:0]      reg_addr_o;
  logic [31:0]      reg_wdata_o;
  logic [3:0]       reg_wstrb_o;
  logic             reg_write_o;
  logic             reg_valid_o;
  logic [31:0]      reg_rdata_i;
  logic             reg_error_i;
  logic             reg_ready_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [1:0]       err_code_o;
  logic [1:0]       err_idx_o;

  slv_guard_cfg_master #(
    .AddrWidth(32), .DataWidth(32), .NumEntries(NE),
    .MaxRetries(MAXR), .TimeoutCycles(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i), .cfg_strb_i(cfg_strb_i),
    .reg_addr_o(reg_addr_o), .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o),
    .reg_write_o(reg_write_o), .reg_valid_o(reg_valid_o),
    .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i), .reg_ready_i(reg_ready_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .err_code_o(err_code_o), .err_idx_o(err_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scenario knobs
  logic [31:0] addr_tab [NE];
  logic [31:0] data_tab [NE];
  logic [3:0]  strb_tab [NE];
  int          errs_tab [NE];
  int          errs_left[NE];
  logic [31:0] wr_mem   [NE];
  int          stall_idx = -1;
  int          lat_fixed = -1;
  bit          rd_ov_en  = 1'b0;
  logic [31:0] rd_ov_val = 32'h0;

  // monitor state
  rec_t obs_q[$];
  rec_t exp_q[$];
  int   cyc = 0, last_hs = -1, vrun = 0, max_vrun = 0, done_cnt = 0;
  int   gap_bad = 0, stab_bad = 0;
  logic prev_valid = 1'b0, prev_hs = 1'b0, prev_wr = 1'b0;
  logic [31:0] prev_addr = 32'h0, prev_data = 32'h0;
  logic [3:0]  prev_strb = 4'h0;

  int exp_code, exp_idx, exp_done;
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int find_ent(input logic [31:0] a);
    for (int i = 0; i < NE; i++) if (addr_tab[i] == a) return i;
    return -1;
  endfunction

  function automatic int pick_lat();
    if (lat_fixed >= 0) return lat_fixed;
    return int'($urandom_range(0, 2));
  endfunction

`ifdef SLV_GUARD_CFG_READBACK_EN
  // byte-by-byte comparison of the strobed lanes
  function automatic bit rb_mismatch(input logic [31:0] rd, input logic [31:0] wd, input logic [3:0] st);
    for (int b = 0; b < 4; b++) if (st[b] && (rd[b*8 +: 8] != wd[b*8 +: 8])) return 1'b1;
    return 1'b0;
  endfunction
`endif

  // Transaction-level prediction of the whole sequence.
  task automatic build_expect();
    rec_t r;
    bit   ok;
    exp_q.delete();
    exp_code = 0; exp_idx = 0; exp_done = 1;
    for (int e = 0; e < NE; e++) begin
      if (e == stall_idx) begin
        exp_code = 2; exp_idx = e; exp_done = 0;
        return;
      end
      ok = 1'b0;
      for (int a = 0; a <= MAXR; a++) begin
        r.wr = 1'b1; r.addr = addr_tab[e]; r.data = data_tab[e]; r.strb = strb_tab[e];
        r.er = (a < errs_tab[e]);
        exp_q.push_back(r);
        if (!r.er) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        exp_code = 1; exp_idx = e; exp_done = 0;
        return;
      end
`ifdef SLV_GUARD_CFG_READBACK_EN
      r.wr = 1'b0; r.er = 1'b0; r.addr = addr_tab[e]; r.data = 32'h0; r.strb = 4'h0;
      exp_q.push_back(r);
      if (rd_ov_en && e == 0 && rb_mismatch(rd_ov_val, data_tab[e], strb_tab[e])) begin
        exp_code = 3; exp_idx = e; exp_done = 0;
        return;
      end
`endif
    end
  endtask

  // Register slave: drives ready/error/rdata shortly after each rising edge.
  initial begin
    int wait_cnt, cur_lat, ent;
    wait_cnt = 0; cur_lat = 0;
    reg_ready_i = 1'b0; reg_error_i = 1'b0; reg_rdata_i = 32'h0;
    forever begin
      @(posedge clk); #1;
      ent = find_ent(reg_addr_o);
      if (reg_valid_o && ent >= 0 && !(reg_write_o && ent == stall_idx)) begin
        if (wait_cnt >= cur_lat) begin
          reg_ready_i = 1'b1; reg_error_i = 1'b0; reg_rdata_i = $urandom;
          if (reg_write_o) begin
            if (errs_left[ent] > 0) begin
              reg_error_i = 1'b1;
              errs_left[ent]--;
            end else begin
              wr_mem[ent] = reg_wdata_o;
            end
          end else begin
            reg_rdata_i = (rd_ov_en && ent == 0) ? rd_ov_val : wr_mem[ent];
          end
          wait_cnt = 0; cur_lat = pick_lat();
        end else begin
          reg_ready_i = 1'b0; reg_error_i = 1'b0; wait_cnt++;
        end
      end else begin
        reg_ready_i = 1'b0; reg_error_i = 1'b0; wait_cnt = 0;
      end
    end
  end

  // Monitor: samples mid-cycle, logs completed transfers and protocol rules.
  initial begin
    rec_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (done_o) done_cnt++;
      if (reg_valid_o) begin
        vrun++;
        if (vrun > max_vrun) max_vrun = vrun;
        if (!prev_valid && last_hs >= 0 && (cyc - last_hs) != 2) gap_bad++;
        if (prev_valid && !prev_hs &&
            (reg_addr_o != prev_addr || reg_write_o != prev_wr ||
             reg_wdata_o != prev_data || reg_wstrb_o != prev_strb)) stab_bad++;
      end else begin
        vrun = 0;
      end
      if (reg_valid_o && reg_ready_i) begin
        r.wr = reg_write_o; r.er = reg_error_i; r.addr = reg_addr_o;
        r.data = reg_write_o ? reg_wdata_o : 32'h0;
        r.strb = reg_write_o ? reg_wstrb_o : 4'h0;
        obs_q.push_back(r);
        last_hs = cyc;
      end
      prev_valid = reg_valid_o; prev_hs = reg_valid_o & reg_ready_i;
      prev_wr = reg_write_o; prev_addr = reg_addr_o;
      prev_data = reg_wdata_o; prev_strb = reg_wstrb_o;
    end
  end

  task automatic pack_cfg();
    for (int e = 0; e < NE; e++) begin
      cfg_addr_i[e*32 +: 32] = addr_tab[e];
      cfg_data_i[e*32 +: 32] = data_tab[e];
      cfg_strb_i[e*4 +: 4]   = strb_tab[e];
      errs_left[e] = errs_tab[e];
      wr_mem[e]    = 32'h0;
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
  endtask

  task automatic run_seq(input string name);
    bit fin;
    int n;
    pack_cfg();
    build_expect();
    obs_q.delete();
    last_hs = -1; max_vrun = 0; done_cnt = 0; gap_bad = 0; stab_bad = 0;
    pulse_start();
    check_eq({name, ".busy_start"}, 128'(busy_o), 128'(1));
    check_eq({name, ".err_clear"},  128'(err_o), 128'(0));
    fin = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_o || err_o) begin fin = 1'b1; break; end
    end
    check_eq({name, ".finished"}, 128'(fin), 128'(1));
    repeat (3) @(negedge clk);
    check_eq({name, ".n_xfer"}, 128'(obs_q.size()), 128'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s.xfer%0d", name, i), 128'(obs_q[i]), 128'(exp_q[i]));
    check_eq({name, ".done_cnt"}, 128'(done_cnt), 128'(exp_done));
    check_eq({name, ".err_o"},    128'(err_o), 128'(exp_code != 0));
    check_eq({name, ".err_code"}, 128'(err_code_o), 128'(exp_code));
    check_eq({name, ".err_idx"},  128'(err_idx_o), 128'(exp_idx));
    check_eq({name, ".busy_end"}, 128'(busy_o), 128'(0));
    check_eq({name, ".gap"},      128'(gap_bad), 128'(0));
    check_eq({name, ".stable"},   128'(stab_bad), 128'(0));
    if (stall_idx >= 0 && exp_code == 2)
      check_eq({name, ".valid_len"}, 128'(max_vrun), 128'(TMO));
  endtask

  task automatic set_basic_cfg();
    addr_tab[0] = 32'h0; data_tab[0] = 32'h1; strb_tab[0] = 4'h1;
    addr_tab[1] = 32'h4; data_tab[1] = 32'h1; strb_tab[1] = 4'hF;
    addr_tab[2] = 32'h8; data_tab[2] = 32'h1; strb_tab[2] = 4'hF;
    for (int e = 0; e < NE; e++) errs_tab[e] = 0;
    stall_idx = -1; rd_ov_en = 1'b0;
  endtask

  // global safety net
  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit found;
    logic [31:0] base;
    start_i = 1'b0;
    cfg_addr_i = '0; cfg_data_i = '0; cfg_strb_i = '0;
    set_basic_cfg();
    rst_n = 1'b1;
    #12;
    check_eq("rst.valid", 128'(reg_valid_o), 128'(0));
    check_eq("rst.busy",  128'(busy_o), 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst.done",  128'(done_o), 128'(0));
    check_eq("rst.err",   128'(err_o), 128'(0));
    check_eq("rst.code",  128'(err_code_o), 128'(0));
    check_eq("rst.addr",  128'(reg_addr_o), 128'(0));
    check_eq("rst.write", 128'(reg_write_o), 128'(0));

    // directed: three clean writes, ready one cycle after valid
    set_basic_cfg(); lat_fixed = 1;
    run_seq("basic");

    // directed: entry 1 errors twice then succeeds
    set_basic_cfg(); errs_tab[1] = 2;
    run_seq("retry2");

    // directed: entry 2 errors forever -> bus error after 4 attempts
    set_basic_cfg(); errs_tab[2] = 4;
    run_seq("buserr");

    // directed: no ready on entry 0 -> timeout; then restart from ERR
    set_basic_cfg(); stall_idx = 0;
    run_seq("timeout");
    set_basic_cfg();
    run_seq("restart");

    // directed: asynchronous reset while entry 1 is on the bus
    set_basic_cfg(); stall_idx = 1; lat_fixed = 0;
    pack_cfg();
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (reg_valid_o && reg_write_o && reg_addr_o == addr_tab[1]) begin found = 1'b1; break; end
    end
    check_eq("arst.reach_e1", 128'(found), 128'(1));
    #2 rst_n = 1'b1;
    #1;
    check_eq("arst.valid", 128'(reg_valid_o), 128'(0));
    check_eq("arst.busy",  128'(busy_o), 128'(0));
    @(negedge clk);
    rst_n = 1'b0;
    set_basic_cfg();
    run_seq("after_rst");

`ifdef SLV_GUARD_CFG_READBACK_EN
    // read-back compares only strobed bytes
    set_basic_cfg(); lat_fixed = 1;
    rd_ov_en = 1'b1; rd_ov_val = 32'hFFFF_FF00;
    run_seq("rb_mismatch");
    set_basic_cfg();
    rd_ov_en = 1'b1; rd_ov_val = 32'hABCD_EF01;
    run_seq("rb_match");
    rd_ov_en = 1'b0;
`endif

    // randomized scenarios
    lat_fixed = -1;
    for (int t = 0; t < 20; t++) begin
      base = $urandom & 32'hFFFF_FF00;
      for (int e = 0; e < NE; e++) begin
        addr_tab[e] = base + 32'(e * 4);
        data_tab[e] = $urandom;
        strb_tab[e] = 4'($urandom_range(1, 15));
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: errs_tab[e] = 0;
          5, 6, 7:       errs_tab[e] = int'($urandom_range(1, 3));
          default:       errs_tab[e] = 4;
        endcase
      end
      stall_idx = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, NE - 1)) : -1;
      rd_ov_en  = 1'b0;
      run_seq($sformatf("rand%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
